controlador_acoes: RTL and testbench

CONTROLADOR_ACOES -- requirements
Module: controlador_acoes

---
 rtl/controlador_acoes.sv | 177 +++++++++++++++++
 tb/tb_controlador_acoes.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_acoes.sv
// controlador_acoes: speed/action sequencer driven by a speed button and a tick strobe.
// States OFF -> IDLE -> RUN, with an optional SLEEP state after a number of
// button-free action laps. The sleep feature is built only when the macro
// AUTO_SLEEP_EN is defined; the default build has no lap counter and never sleeps.
// Every output comes straight from a register.
module controlador_acoes #(
  parameter int NUM_ACTS   = 6,
  parameter int SLEEP_LAPS = 8
) (
  input  logic       clk,
  input  logic       rst_but,
  input  logic       on_off,
  input  logic       tick,
  input  logic       btn_spd,
  output logic [1:0] spd,
  output logic [2:0] act,
  output logic       act_stb,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_IDLE  = 2'b01,
    ST_RUN   = 2'b10,
    ST_SLEEP = 2'b11
  } state_t;

  localparam logic [2:0] LAST_ACT = 3'(NUM_ACTS - 1);

  state_t     state_q, state_d;
  logic [1:0] spd_q, spd_d;
  logic [2:0] act_q, act_d;
  logic       stb_q, stb_d;
  logic [1:0] presc_q, presc_d;
  logic       btn_prev_q, btn_prev_d;
  logic       btn_edge;
  logic [1:0] presc_last;
  logic       act_wrap;

`ifdef AUTO_SLEEP_EN
  localparam logic [3:0] SLEEP_LAPS_C = 4'(SLEEP_LAPS);
  logic [3:0] lap_q, lap_d;
`endif

  assign btn_edge = btn_spd & ~btn_prev_q;
  assign act_wrap = (act_q == LAST_ACT);

  // Last prescaler value of an action period: 4, 2 or 1 ticks per action.
  always_comb begin
    case (spd_q)
      2'd1:    presc_last = 2'd3;
      2'd2:    presc_last = 2'd1;
      default: presc_last = 2'd0;
    endcase
  end

  // Next-state logic: button edge beats tick, on_off=0 beats everything.
  always_comb begin
    state_d    = state_q;
    spd_d      = spd_q;
    act_d      = act_q;
    stb_d      = 1'b0;
    presc_d    = presc_q;
    btn_prev_d = btn_spd;
`ifdef AUTO_SLEEP_EN
    lap_d      = lap_q;
`endif

    if (!on_off) begin
      state_d = ST_OFF;
      spd_d   = 2'd0;
      act_d   = 3'd0;
      presc_d = 2'd0;
`ifdef AUTO_SLEEP_EN
      lap_d   = 4'd0;
`endif
    end else begin
      case (state_q)
        ST_OFF: begin
          // Power-up cycle: a coincident button edge is deliberately dropped.
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (btn_edge) begin
            state_d = ST_RUN;
            spd_d   = 2'd1;
            presc_d = 2'd0;
`ifdef AUTO_SLEEP_EN
            lap_d   = 4'd0;
`endif
          end
        end
        ST_RUN: begin
          if (btn_edge) begin
            presc_d = 2'd0;
`ifdef AUTO_SLEEP_EN
            lap_d   = 4'd0;
`endif
            if (spd_q == 2'd3) begin
              state_d = ST_IDLE;
              spd_d   = 2'd0;
            end else begin
              spd_d = spd_q + 2'd1;
            end
`ifdef AUTO_SLEEP_EN
          end else if (lap_q == SLEEP_LAPS_C) begin
            state_d = ST_SLEEP;
            spd_d   = 2'd0;
            act_d   = 3'd0;
            presc_d = 2'd0;
            lap_d   = 4'd0;
`endif
          end else if (tick) begin
            if (presc_q == presc_last) begin
              presc_d = 2'd0;
              stb_d   = 1'b1;
              act_d   = act_wrap ? 3'd0 : act_q + 3'd1;
`ifdef AUTO_SLEEP_EN
              if (act_wrap) lap_d = lap_q + 4'd1;
`endif
            end else begin
              presc_d = presc_q + 2'd1;
            end
          end
        end
`ifdef AUTO_SLEEP_EN
        ST_SLEEP: begin
          if (btn_edge) begin
            state_d = ST_RUN;
            spd_d   = 2'd1;
            presc_d = 2'd0;
            lap_d   = 4'd0;
          end
        end
`endif
        default: begin
          state_d = ST_OFF;
          spd_d   = 2'd0;
          act_d   = 3'd0;
          presc_d = 2'd0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; btn_prev resets high
  // so a button held through reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_but) begin
      state_q    <= ST_OFF;
      spd_q      <= 2'd0;
      act_q      <= 3'd0;
      stb_q      <= 1'b0;
      presc_q    <= 2'd0;
      btn_prev_q <= 1'b1;
`ifdef AUTO_SLEEP_EN
      lap_q      <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      spd_q      <= spd_d;
      act_q      <= act_d;
      stb_q      <= stb_d;
      presc_q    <= presc_d;
      btn_prev_q <= btn_prev_d;
`ifdef AUTO_SLEEP_EN
      lap_q      <= lap_d;
`endif
    end
  end

  assign spd     = spd_q;
  assign act     = act_q;
  assign act_stb = stb_q;
  assign state   = state_q;

endmodule

// File: tb/tb_controlador_acoes.sv
// Scoreboard bench for controlador_acoes: stimulus pushes expected action
// strobes and expected {state,spd,act} transitions into queues; a monitor pops
// and compares whenever the DUT strobes act_stb or changes state/spd.
module tb_controlador_acoes;

  localparam logic [1:0] S_OFF = 2'b00, S_IDLE = 2'b01, S_RUN = 2'b10, S_SLEEP = 2'b11;

  logic       clk, rst_but, on_off, tick, btn_spd;
  logic [1:0] spd;
  logic [2:0] act;
  logic       act_stb;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_ss;
  logic [2:0] exp_act_q[$];
  logic [6:0] exp_ss_q[$];

  controlador_acoes #(.NUM_ACTS(6), .SLEEP_LAPS(2)) dut (
    .clk(clk), .rst_but(rst_but), .on_off(on_off), .tick(tick), .btn_spd(btn_spd),
    .spd(spd), .act(act), .act_stb(act_stb), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic b, input logic t);
    btn_spd = b;
    tick    = t;
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic exp_ss(input logic [1:0] s, input logic [1:0] sp, input logic [2:0] a);
    exp_ss_q.push_back({s, sp, a});
  endtask

  // Monitor: compares on every strobe and on every state/speed change.
  initial begin
    logic [2:0] ea;
    logic [6:0] es;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (act_stb === 1'b1) begin
          checks++;
          if (exp_act_q.size() == 0) begin
            failures++;
            $display("FAIL act_stb_unexpected act=%0d required=no_strobe", act);
          end else begin
            ea = exp_act_q.pop_front();
            if (act !== ea) begin
              failures++;
              $display("FAIL act_on_stb actual=%0d required=%0d", act, ea);
            end
          end
        end
        if ({state, spd} !== prev_ss) begin
          checks++;
          if (exp_ss_q.size() == 0) begin
            failures++;
            $display("FAIL ss_unexpected state=%0d spd=%0d act=%0d required=no_change", state, spd, act);
          end else begin
            es = exp_ss_q.pop_front();
            if ({state, spd, act} !== es) begin
              failures++;
              $display("FAIL ss_change actual state=%0d spd=%0d act=%0d required state=%0d spd=%0d act=%0d",
                       state, spd, act, es[6:5], es[4:3], es[2:0]);
            end
          end
          prev_ss = {state, spd};
        end
      end
    end
  end

  initial begin
    // Reset with on_off high and the button held: reset must win.
    rst_but = 1'b0;
    on_off  = 1'b1;
    btn_spd = 1'b1;
    tick    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_spd", int'(spd), 0);
    chk("reset_act", int'(act), 0);
    chk("reset_stb", int'(act_stb), 0);

    prev_ss = {state, spd};
    mon_en  = 1'b1;
    rst_but = 1'b1;

    // OFF -> IDLE; held button through reset release gives no edge.
    exp_ss(S_IDLE, 2'd0, 3'd0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);

    // Ticks in IDLE are ignored.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);

    // One press, then 4 ticks at spd=1 -> act 0->1 once.
    exp_ss(S_RUN, 2'd1, 3'd0);
    press();
    exp_act_q.push_back(3'd1);
    repeat (4) begin
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
    end

    // Cycle speeds back to IDLE, then four presses from IDLE: 1,2,3,0.
    exp_ss(S_RUN, 2'd2, 3'd1);
    exp_ss(S_RUN, 2'd3, 3'd1);
    exp_ss(S_IDLE, 2'd0, 3'd1);
    repeat (3) press();
    exp_ss(S_RUN, 2'd1, 3'd1);
    exp_ss(S_RUN, 2'd2, 3'd1);
    exp_ss(S_RUN, 2'd3, 3'd1);
    exp_ss(S_IDLE, 2'd0, 3'd1);
    repeat (4) press();

    // Up to spd=2, then a button edge coincident with the second tick.
    exp_ss(S_RUN, 2'd1, 3'd1);
    press();
    exp_ss(S_RUN, 2'd2, 3'd1);
    press();
    drive(1'b0, 1'b1);
    exp_ss(S_RUN, 2'd3, 3'd1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);

    // spd=3: every tick advances, including the wrap 5 -> 0.
    exp_act_q.push_back(3'd2);
    exp_act_q.push_back(3'd3);
    exp_act_q.push_back(3'd4);
    exp_act_q.push_back(3'd5);
    exp_act_q.push_back(3'd0);
    exp_act_q.push_back(3'd1);
    repeat (6) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    exp_act_q.push_back(3'd2);
    exp_act_q.push_back(3'd3);
    repeat (2) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);

    // Power drop at act=3, tick while off, then power back with a button edge
    // in the OFF->IDLE cycle which must be ignored.
    exp_ss(S_OFF, 2'd0, 3'd0);
    on_off = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    exp_ss(S_IDLE, 2'd0, 3'd0);
    on_off = 1'b1;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // spd=3 with 12 ticks: two full laps.
    exp_ss(S_RUN, 2'd1, 3'd0);
    exp_ss(S_RUN, 2'd2, 3'd0);
    exp_ss(S_RUN, 2'd3, 3'd0);
    repeat (3) press();
`ifdef AUTO_SLEEP_EN
    exp_ss(S_SLEEP, 2'd0, 3'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      logic [2:0] a;
      a = 3'((i + 1) % 6);
      exp_act_q.push_back(a);
    end
    repeat (12) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
`ifdef AUTO_SLEEP_EN
    exp_ss(S_RUN, 2'd1, 3'd0);
    press();
    exp_act_q.push_back(3'd1);
    repeat (4) drive(1'b0, 1'b1);
`else
    exp_ss(S_IDLE, 2'd0, 3'd0);
    press();
`endif
    repeat (3) drive(1'b0, 1'b0);

    chk("act_queue_left", exp_act_q.size(), 0);
    chk("ss_queue_left", exp_ss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
